// File: rtl/mem_port_arbiter_if.sv
// Core/memory signal bundle for the unified-memory port arbiter.
// The slave modport is the arbiter's view; master is the core plus memory model.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory with
// round-robin arbitration on contention and per-requester ready pulses.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflicts
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {FETCH, DATA} owner_t;

    localparam logic [3:0] WAIT_INIT = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : '0;

    state_t           state, state_n;
    owner_t           owner, owner_n;
    owner_t           last_grant, last_grant_n;
    owner_t           grant;
    logic [3:0]       cnt, cnt_n;
    logic [CNT_W-1:0] conflicts_n;
    logic             we_n;
    logic [31:0]      addr_n, wdata_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= FETCH;
            last_grant    <= FETCH;
            cnt           <= '0;
            conflicts     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            last_grant    <= last_grant_n;
            cnt           <= cnt_n;
            conflicts     <= conflicts_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_wdata <= wdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        conflicts_n  = conflicts;
        we_n         = bus.mem_we;
        addr_n       = bus.mem_addr;
        wdata_n      = bus.mem_wdata;
        grant        = FETCH;
        bus.mem_en   = 1'b0;
        bus.if_ready = 1'b0;
        bus.d_ready  = 1'b0;
        bus.if_rdata = '0;
        bus.d_rdata  = '0;

        case (state)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    if (bus.if_req && bus.d_req) begin
                        grant = (last_grant == FETCH) ? DATA : FETCH;
                        if (conflicts != '1)
                            conflicts_n = conflicts + CNT_W'(1);
                    end else begin
                        grant = bus.d_req ? DATA : FETCH;
                    end
                    owner_n      = grant;
                    last_grant_n = grant;
                    state_n      = ISSUE;
                    if (grant == DATA) begin
                        addr_n  = bus.d_addr;
                        we_n    = bus.d_we;
                        wdata_n = bus.d_wdata;
                    end else begin
                        addr_n  = bus.if_addr;
                        we_n    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                // Stores and single-cycle reads skip the wait counter entirely.
                if (bus.mem_we || MEM_LATENCY == 1) begin
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                    cnt_n   = WAIT_INIT;
                end
            end
            WAIT: begin
                if (cnt == '0)
                    state_n = DONE;
                else
                    cnt_n = cnt - 4'd1;
            end
            DONE: begin
                if (owner == DATA) begin
                    bus.d_ready = 1'b1;
                    bus.d_rdata = bus.mem_rdata;
                end else begin
                    bus.if_ready = 1'b1;
                    bus.if_rdata = bus.mem_rdata;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (latency 2 / 16-bit
// counter, latency 1 / 4-bit counter), each with its own memory model.
module tb_mem_port_arbiter;

    localparam int LA = 2;
    localparam int LB = 1;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rsta, rstb;
    logic [15:0] conf_a;
    logic [3:0]  conf_b;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;

    logic [31:0] mema[64];
    logic [31:0] memb[64];
    logic [5:0]  rda = '0, rdb = '0;
    logic [3:0]  dlya = '0, dlyb = '0;

    mem_port_arbiter_if ia();
    mem_port_arbiter_if ib();

    mem_port_arbiter #(.MEM_LATENCY(LA), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rsta), .bus(ia.slave), .conflicts(conf_a));
    mem_port_arbiter #(.MEM_LATENCY(LB), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rstb), .bus(ib.slave), .conflicts(conf_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: read data is valid only in the single cycle LAT after mem_en.
    always @(posedge clk) begin
        if (ia.mem_en && ia.mem_we) mema[ia.mem_addr[7:2]] <= ia.mem_wdata;
        if (ia.mem_en && !ia.mem_we) begin
            rda <= ia.mem_addr[7:2]; dlya <= 4'd1;
        end else if (dlya != 0 && dlya < LA) dlya <= dlya + 4'd1;
        else dlya <= '0;
        if (ib.mem_en && ib.mem_we) memb[ib.mem_addr[7:2]] <= ib.mem_wdata;
        if (ib.mem_en && !ib.mem_we) begin
            rdb <= ib.mem_addr[7:2]; dlyb <= 4'd1;
        end else if (dlyb != 0 && dlyb < LB) dlyb <= dlyb + 4'd1;
        else dlyb <= '0;
    end
    assign ia.mem_rdata = (dlya == LA) ? mema[rda] : 32'hDEAD_BEEF;
    assign ib.mem_rdata = (dlyb == LB) ? memb[rdb] : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        compared++;
        if ((!ia.if_ready && ia.if_rdata !== 0) || (!ia.d_ready && ia.d_rdata !== 0)) begin
            mismatched++;
            $display("FAIL a_idle_rdata: if_rdata=%h d_rdata=%h required 0 without ready", ia.if_rdata, ia.d_rdata);
        end
        if (ia.if_ready || ia.d_ready) begin
            compared++;
            if (ia.if_ready && ia.d_ready) begin
                mismatched++;
                $display("FAIL a_both_ready: both readys high at cycle %0d", cyc);
            end else if (qa.size() == 0) begin
                mismatched++;
                $display("FAIL a_unexpected_ready: if_ready=%b d_ready=%b at cycle %0d, none expected", ia.if_ready, ia.d_ready, cyc);
            end else begin
                ea = qa.pop_front();
                if (ia.d_ready !== ea.is_d) begin
                    mismatched++;
                    $display("FAIL a_owner: d_ready=%b required %b at cycle %0d", ia.d_ready, ea.is_d, cyc);
                end
                if (ea.chk) begin
                    compared++;
                    if ((ea.is_d ? ia.d_rdata : ia.if_rdata) !== ea.data) begin
                        mismatched++;
                        $display("FAIL a_rdata: got %h required %h", ea.is_d ? ia.d_rdata : ia.if_rdata, ea.data);
                    end
                end
                if (ea.cyc >= 0) begin
                    compared++;
                    if (cyc != ea.cyc) begin
                        mismatched++;
                        $display("FAIL a_ready_cycle: ready at %0d required %0d", cyc, ea.cyc);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        compared++;
        if ((!ib.if_ready && ib.if_rdata !== 0) || (!ib.d_ready && ib.d_rdata !== 0)) begin
            mismatched++;
            $display("FAIL b_idle_rdata: if_rdata=%h d_rdata=%h required 0 without ready", ib.if_rdata, ib.d_rdata);
        end
        if (ib.if_ready || ib.d_ready) begin
            compared++;
            if (ib.if_ready && ib.d_ready) begin
                mismatched++;
                $display("FAIL b_both_ready: both readys high at cycle %0d", cyc);
            end else if (qb.size() == 0) begin
                mismatched++;
                $display("FAIL b_unexpected_ready: if_ready=%b d_ready=%b at cycle %0d, none expected", ib.if_ready, ib.d_ready, cyc);
            end else begin
                eb = qb.pop_front();
                if (ib.d_ready !== eb.is_d) begin
                    mismatched++;
                    $display("FAIL b_owner: d_ready=%b required %b at cycle %0d", ib.d_ready, eb.is_d, cyc);
                end
                if (eb.chk) begin
                    compared++;
                    if ((eb.is_d ? ib.d_rdata : ib.if_rdata) !== eb.data) begin
                        mismatched++;
                        $display("FAIL b_rdata: got %h required %h", eb.is_d ? ib.d_rdata : ib.if_rdata, eb.data);
                    end
                end
                if (eb.cyc >= 0) begin
                    compared++;
                    if (cyc != eb.cyc) begin
                        mismatched++;
                        $display("FAIL b_ready_cycle: ready at %0d required %0d", cyc, eb.cyc);
                    end
                end
            end
        end
    end

    // Waits (bounded) for the chosen ready, then returns just after the next edge.
    task automatic wait_ready(input bit on_b, input bit is_d);
        bit got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (on_b ? (is_d ? ib.d_ready : ib.if_ready) : (is_d ? ia.d_ready : ia.if_ready)) begin
                got = 1'b1;
                break;
            end
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL ready_timeout: dut=%s port=%s ready=0 required 1 within 40 cycles", on_b ? "b" : "a", is_d ? "d" : "if");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rsta = 1'b1; rstb = 1'b1;
        @(posedge clk); @(negedge clk);
        compared++;
        if ({ia.mem_en, ia.mem_we, ia.if_ready, ia.d_ready} !== 4'b0 || ia.mem_addr !== 0 ||
            ia.mem_wdata !== 0 || ia.if_rdata !== 0 || ia.d_rdata !== 0 || conf_a !== 0) begin
            mismatched++;
            $display("FAIL reset_a: en=%b we=%b addr=%h wdata=%h conf=%0d required all 0", ia.mem_en, ia.mem_we, ia.mem_addr, ia.mem_wdata, conf_a);
        end
        compared++;
        if ({ib.mem_en, ib.mem_we, ib.if_ready, ib.d_ready} !== 4'b0 || ib.mem_addr !== 0 ||
            ib.mem_wdata !== 0 || conf_b !== 0) begin
            mismatched++;
            $display("FAIL reset_b: en=%b we=%b addr=%h conf=%0d required all 0", ib.mem_en, ib.mem_we, ib.mem_addr, conf_b);
        end
        @(posedge clk); #1;
        rsta = 1'b0; rstb = 1'b0;
    endtask

    task automatic test_single_fetch();
        qa.push_back('{1'b0, 32'he2801032, 1'b1, cyc + LA + 1});
        ia.if_req = 1'b1; ia.if_addr = 32'h08;
        @(negedge clk);
        compared++;
        if (ia.mem_en !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_en_early: mem_en=%b required 0", ia.mem_en);
        end
        @(negedge clk);
        compared++;
        if (ia.mem_en !== 1'b1 || ia.mem_addr !== 32'h08 || ia.mem_we !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_issue: en=%b addr=%h we=%b required 1/00000008/0", ia.mem_en, ia.mem_addr, ia.mem_we);
        end
        wait_ready(1'b0, 1'b0);
        ia.if_req = 1'b0;
        @(negedge clk);
        compared++;
        if (ia.mem_en !== 1'b0) begin
            mismatched++;
            $display("FAIL fetch_single_strobe: mem_en=%b required 0 after access", ia.mem_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        qa.push_back('{1'b1, 32'h0, 1'b0, cyc + 2});
        ia.d_req = 1'b1; ia.d_we = 1'b1; ia.d_addr = 32'h64; ia.d_wdata = 32'h7;
        wait_ready(1'b0, 1'b1);
        qa.push_back('{1'b1, 32'h7, 1'b1, cyc + LA + 1});
        ia.d_we = 1'b0; ia.d_wdata = 32'h55;
        wait_ready(1'b0, 1'b1);
        ia.d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        qa.push_back('{1'b1, mema[4], 1'b1, -1});
        qa.push_back('{1'b0, mema[0], 1'b1, -1});
        qa.push_back('{1'b1, mema[5], 1'b1, -1});
        qa.push_back('{1'b0, mema[1], 1'b1, -1});
        fork
            begin
                ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 32'h10;
                wait_ready(1'b0, 1'b1);
                ia.d_addr = 32'h14;
                wait_ready(1'b0, 1'b1);
                ia.d_req = 1'b0;
            end
            begin
                @(posedge clk); #1;
                ia.if_req = 1'b1; ia.if_addr = 32'h00;
                wait_ready(1'b0, 1'b0);
                ia.if_addr = 32'h04;
                wait_ready(1'b0, 1'b0);
                ia.if_req = 1'b0;
            end
        join
        @(negedge clk);
        compared++;
        if (conf_a !== 16'd2) begin
            mismatched++;
            $display("FAIL contention_conflicts: conflicts=%0d required 2", conf_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency1();
        for (int k = 0; k < 3; k++) begin
            qb.push_back('{1'b0, memb[k], 1'b1, cyc + LB + 1});
            ib.if_req = 1'b1; ib.if_addr = 32'(4 * k);
            wait_ready(1'b1, 1'b0);
        end
        ib.if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsta = 1'b1; ia.d_req = 1'b0;
        @(posedge clk); @(negedge clk);
        compared++;
        if ({ia.mem_en, ia.mem_we, ia.if_ready, ia.d_ready} !== 4'b0 || ia.mem_addr !== 0 ||
            ia.mem_wdata !== 0 || ia.if_rdata !== 0 || ia.d_rdata !== 0 || conf_a !== 0) begin
            mismatched++;
            $display("FAIL reset_mid: en=%b we=%b rdy=%b/%b addr=%h conf=%0d required all 0", ia.mem_en, ia.mem_we, ia.if_ready, ia.d_ready, ia.mem_addr, conf_a);
        end
        @(posedge clk); #1;
        rsta = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        qa.push_back('{1'b0, mema[3], 1'b1, cyc + LA + 1});
        ia.if_req = 1'b1; ia.if_addr = 32'h0C;
        wait_ready(1'b0, 1'b0);
        ia.if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        rstb = 1'b1;
        @(posedge clk); #1;
        rstb = 1'b0;
        for (int k = 0; k < 10; k++) begin
            qb.push_back('{1'b1, memb[16 + k], 1'b1, -1});
            qb.push_back('{1'b0, memb[32 + k], 1'b1, -1});
        end
        fork
            begin
                ib.d_req = 1'b1; ib.d_we = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    ib.d_addr = 32'(64 + 4 * k);
                    wait_ready(1'b1, 1'b1);
                end
                ib.d_req = 1'b0;
            end
            begin
                ib.if_req = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    ib.if_addr = 32'(128 + 4 * k);
                    wait_ready(1'b1, 1'b0);
                end
                ib.if_req = 1'b0;
            end
        join
        @(negedge clk);
        compared++;
        if (conf_b !== 4'd15) begin
            mismatched++;
            $display("FAIL saturation: conflicts=%0d required 15", conf_b);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mema[i] = 32'hA500_0000 + 32'(i);
            memb[i] = 32'h5B00_0000 + 32'(i * 3);
        end
        mema[2] = 32'he2801032;
        {ia.if_req, ia.d_req, ia.d_we} = '0;
        {ia.if_addr, ia.d_addr, ia.d_wdata} = '0;
        {ib.if_req, ib.d_req, ib.d_we} = '0;
        {ib.if_addr, ib.d_addr, ib.d_wdata} = '0;
        @(posedge clk); #1;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_latency1();
        test_reset_mid();
        test_saturation();
        repeat (4) @(posedge clk);
        compared++;
        if (qa.size() != 0 || qb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
